// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through FIFO
module uart_rx_fifo #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               RXD,
  output logic [7:0]                         M_DATA,
  output logic                               M_VALID,
  input  logic                               M_READY,
  output logic                               FRAME_ERR,
  output logic                               OVERFLOW,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    LEVEL
);

  localparam int DIV  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rxd_meta_q, rxd_s_q;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic            push;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic            full, empty, pop, wr_en;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rxd_meta_q  <= RXD;
      rxd_s_q     <= rxd_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit leaves half a bit of slack for a back-to-back start edge.
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer MSB differs and the rest matches only when full.
  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
  assign pop        = M_VALID & M_READY;
  assign wr_en      = push & (~full | pop);
  assign overflow_d = push & full & ~pop;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= shift_q;
      wptr_q <= wptr_q + PW'(wr_en);
      rptr_q <= rptr_q + PW'(pop);
    end
  end

  assign M_DATA    = mem_q[rptr_q[AW-1:0]];
  assign M_VALID   = ~empty;
  assign LEVEL     = wptr_q - rptr_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling-free UART receiver (8N1) with a first-word-fall-through receive FIFO. It sits between the board RxD pin and the echo/transmit path. It synchronizes the asynchronous serial line, recovers bytes by mid-bit sampling, and presents them on a valid/ready stream so the downstream consumer can stall without losing data up to FIFO_DEPTH bytes.

## Interface
- CLOCK_FREQUENCY, 100_000_000: CLK frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- FIFO_DEPTH, 16: receive FIFO entries. Must be a power of two and at least 2.
- Derived: DIV = CLOCK_FREQUENCY / BAUD_RATE, truncated (868 at defaults). HALF = DIV / 2, truncated (434).

- CLK, input, 1: single clock domain. All logic is on the rising edge.
- RST_N, input, 1: reset, synchronous and active-low.
- RXD, input, 1: asynchronous serial input. Idle level is high.
- M_DATA, output, 8: head-of-FIFO byte. Valid only while M_VALID is high.
- M_VALID, output, 1: FIFO not empty.
- M_READY, input, 1: consumer accepts the head byte when M_VALID and M_READY are both high on the same edge.
- FRAME_ERR, output, 1: one-cycle pulse when a stop bit is sampled low.
- OVERFLOW, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- LEVEL, output, $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- **Synchronizer.** RXD passes through 2 flops to produce rxd_s. The synchronizer flops reset to 1.
- **Receive FSM** (states IDLE, START, DATA, STOP, BREAK). It uses a bit counter cnt (0..DIV-1) and a bit index idx (0..7).
  - IDLE: when rxd_s = 0, go to START with cnt = 0.
  - START: at cnt = HALF-1, if rxd_s = 0 go to DATA with cnt = 0 and idx = 0. Otherwise (glitch) return to IDLE.
  - DATA: at cnt = DIV-1, shift rxd_s into the shift register LSB-first and set cnt = 0. After idx = 7, go to STOP; otherwise increment idx.
  - STOP: at cnt = DIV-1, sample rxd_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse FRAME_ERR, discard the byte and go to BREAK.
  - BREAK: stay until rxd_s = 1, then go to IDLE. A held-low line produces exactly one FRAME_ERR and never re-triggers.
- **FIFO.** Circular buffer with read/write pointers of width log2(FIFO_DEPTH)+1; the extra MSB distinguishes full from empty. M_DATA is driven from the head entry (fall-through).
  - Pop: M_VALID & M_READY.
  - Push while full and not popping: byte dropped, OVERFLOW pulses, contents unchanged.
  - Push and pop on the same edge while full: both execute, no OVERFLOW, LEVEL unchanged.
  - Push and pop on the same edge while empty cannot occur, because M_VALID is 0.
  - LEVEL += push_accepted - pop.
- **Reset values** (RST_N = 0 on an edge):
  - FSM = IDLE; cnt, idx and shift register = 0.
  - Pointers = 0, LEVEL = 0, M_VALID = 0, M_DATA = 0 (head of the cleared buffer).
  - FRAME_ERR = 0, OVERFLOW = 0.
  - A frame in progress is abandoned. FIFO contents are lost.
  - After reset release, the FSM resynchronizes on the next falling edge seen in IDLE. A partial frame may produce one garbage byte or one FRAME_ERR, which is acceptable.

## Timing
- Let edge 0 be the first CLK edge at which the first synchronizer flop captures RXD = 0.
  - rxd_s = 0 from edge 1.
  - Start-bit check at edge 1+HALF.
  - Data bit k is sampled at edge 1+HALF+(k+1)·DIV.
  - Stop bit is sampled at edge 1+HALF+9·DIV. FRAME_ERR is high for the cycle following that edge.
  - M_VALID is high from edge 2+HALF+9·DIV.
- The bench tolerates ±2 cycles. Back-to-back frames with zero idle time are received, because STOP returns to IDLE at mid stop bit.
- A pop takes effect on the edge. The next byte (or M_VALID = 0) appears in the following cycle.
- Sustained throughput is one pop per cycle.
- Baud tolerance: ±2 % between transmitter and DIV·BAUD_RATE.

## Test plan
- **Single byte:** reset, then send 0x55 at 115200 with M_READY = 1 → one M_VALID cycle with M_DATA = 0x55, FRAME_ERR = 0, LEVEL returns to 0.
- **Back-to-back:** send 0xA5 then 0x3C with no idle gap, M_READY = 0 → LEVEL = 2. Raising M_READY yields 0xA5 then 0x3C on consecutive cycles, then M_VALID = 0.
- **Overflow:** with M_READY = 0, send 17 bytes 0x00..0x10 → LEVEL = 16 and exactly one OVERFLOW pulse at byte 0x10. Draining yields 0x00..0x0F in order. Additionally, pushing while full with M_READY = 1 on the push cycle produces no OVERFLOW.
- **Framing error:**
  - Send 0xFF with stop bit low, then hold RXD low for 3 bit times → exactly one FRAME_ERR pulse, LEVEL = 0.
  - Release RXD high, then send 0x12 → 0x12 received.
- **Glitch:** pull RXD low for 200 cycles (< HALF) → no byte, no FRAME_ERR, FSM back in IDLE. A subsequent 0x81 is received correctly.
- **Reset mid-operation:**
  - Hold LEVEL = 3, then assert RST_N = 0 for 1 cycle during data bit 4 of a frame → LEVEL = 0, M_VALID = 0.
  - After line idle for one frame time, send 0xC3 → 0xC3 received.
